// File: rtl/maxpool_pkg.sv
// maxpool_pkg: state encoding and geometry helpers shared by the pooling sequencer
package maxpool_pkg;

    typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, FIN} state_t;

    function automatic int out_h(input int in_h, input int pool);
        return in_h / pool;
    endfunction

    function automatic int out_w(input int in_w, input int pool);
        return in_w / pool;
    endfunction

    function automatic int win(input int pool);
        return pool * pool;
    endfunction

    // True when addr_w bits can address every element 0..ch*h*w-1
    function automatic bit addr_ok(input int addr_w, input int ch, input int h, input int w);
        return (longint'(ch) * h * w) <= (longint'(1) << addr_w);
    endfunction

endpackage

// File: rtl/Max.sv
// Max: combinational signed maximum over LENGTH packed elements
// Ports: data (LENGTH elements, slot i at [i*BITWIDTH +: BITWIDTH]), result (signed max).
// The running maximum starts at the floor -(2^(BITWIDTH-1)-1), so an all-minimum window
// returns the floor rather than the most negative value.
module Max #(
    parameter int BITWIDTH = 16,
    parameter int LENGTH   = 4
) (
    input  logic [LENGTH*BITWIDTH-1:0] data,
    output logic signed [BITWIDTH-1:0] result
);
    localparam logic signed [BITWIDTH-1:0] FLOOR = {1'b1, {(BITWIDTH-2){1'b0}}, 1'b1};

    always_comb begin
        result = FLOOR;
        for (int i = 0; i < LENGTH; i++)
            result = $signed(data[i*BITWIDTH +: BITWIDTH]) > result ? data[i*BITWIDTH +: BITWIDTH] : result;
    end

endmodule

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: sequences POOLxPOOL window reads into Max and writes pooled results
// Ports: clk/rst (sync active-high); start/busy/done handshake with the layer controller;
// rd_en/rd_addr/rd_data to the input buffer (1-cycle read latency);
// wr_en/wr_ready/wr_addr/wr_data valid/ready write to the output buffer.
module maxpool_ctrl
    import maxpool_pkg::*;
#(
    parameter int BITWIDTH = 16,
    parameter int IN_H     = 28,
    parameter int IN_W     = 28,
    parameter int CHANNELS = 6,
    parameter int POOL     = 2,
    parameter int ADDR_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [BITWIDTH-1:0] rd_data,
    output logic                wr_en,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [BITWIDTH-1:0] wr_data
);
    localparam int OH = out_h(IN_H, POOL);
    localparam int OW = out_w(IN_W, POOL);
    localparam int WN = win(POOL);

    localparam logic [ADDR_W-1:0] P       = ADDR_W'(POOL);
    localparam logic [ADDR_W-1:0] IW      = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] IMAP    = ADDR_W'(IN_H * IN_W);
    localparam logic [ADDR_W-1:0] OWA     = ADDR_W'(OW);
    localparam logic [ADDR_W-1:0] OMAP    = ADDR_W'(OH * OW);
    localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(WN - 1);
    localparam logic [ADDR_W-1:0] OX_LAST = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] OY_LAST = ADDR_W'(OH - 1);
    localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(CHANNELS - 1);

    if (!addr_ok(ADDR_W, CHANNELS, IN_H, IN_W)) begin : g_bad_addr_w
        $error("maxpool_ctrl: ADDR_W too narrow for CHANNELS*IN_H*IN_W");
    end

    state_t state;
    logic [ADDR_W-1:0] c, oy, ox, k;
    logic [WN*BITWIDTH-1:0] window;
    logic ox_end, oy_end, final_out, cap;
    logic [ADDR_W-1:0] nc, noy, nox, slot;

    function automatic logic [ADDR_W-1:0] raddr(input logic [ADDR_W-1:0] cc, yy, xx, kk);
        return cc * IMAP + (yy * P + kk / P) * IW + xx * P + kk % P;
    endfunction

    // Data for read k lands one cycle later, so READ k stores slot k-1 and LAST stores the final slot
    always_comb begin
        ox_end    = ox == OX_LAST;
        oy_end    = oy == OY_LAST;
        final_out = ox_end && oy_end && c == C_LAST;
        nox       = ox_end ? '0 : ox + 1'b1;
        noy       = ox_end ? (oy_end ? '0 : oy + 1'b1) : oy;
        nc        = ox_end && oy_end ? c + 1'b1 : c;
        cap       = (state == READ && k != '0) || state == LAST;
        slot      = state == LAST ? k : k - 1'b1;
    end

    Max #(.BITWIDTH(BITWIDTH), .LENGTH(WN)) u_max (
        .data   (window),
        .result (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            c       <= '0;
            oy      <= '0;
            ox      <= '0;
            k       <= '0;
            window  <= '0;
        end else begin
            done <= 1'b0;
            for (int i = 0; i < WN; i++)
                if (cap && slot == ADDR_W'(i)) window[i*BITWIDTH +: BITWIDTH] <= rd_data;
            case (state)
                IDLE: if (start) begin
                    state   <= READ;
                    busy    <= 1'b1;
                    rd_en   <= 1'b1;
                    rd_addr <= '0;
                    c       <= '0;
                    oy      <= '0;
                    ox      <= '0;
                    k       <= '0;
                end
                READ: if (k == K_LAST) begin
                    state <= LAST;
                    rd_en <= 1'b0;
                end else begin
                    k       <= k + 1'b1;
                    rd_addr <= raddr(c, oy, ox, k + 1'b1);
                end
                LAST: begin
                    state   <= WRITE;
                    wr_en   <= 1'b1;
                    wr_addr <= c * OMAP + oy * OWA + ox;
                end
                WRITE: if (wr_ready) begin
                    wr_en <= 1'b0;
                    c     <= nc;
                    oy    <= noy;
                    ox    <= nox;
                    k     <= '0;
                    if (final_out) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= READ;
                        rd_en   <= 1'b1;
                        rd_addr <= raddr(nc, noy, nox, '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb_maxpool_ctrl: scoreboard bench for maxpool_ctrl on 4x4 maps with one and two channels
module tb_maxpool_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic start1, busy1, done1, rd_en1, wr_en1, wr_ready1;
    logic [15:0] rd_addr1, rd_data1, wr_addr1, wr_data1;
    logic start2, busy2, done2, rd_en2, wr_en2, wr_ready2;
    logic [15:0] rd_addr2, rd_data2, wr_addr2, wr_data2;

    logic [15:0] mem1 [16];
    logic [15:0] mem2 [32];
    logic [31:0] q1[$], q2[$];
    logic [15:0] rlog1[$], rlog2[$];
    int tests = 0, fails = 0;
    int writes1 = 0, dones1 = 0;
    int first_win[4] = '{0, 1, 4, 5};
    int s1_data[4] = '{5, 7, 13, 15};

    always #5 clk = ~clk;

    maxpool_ctrl #(.BITWIDTH(16), .IN_H(4), .IN_W(4), .CHANNELS(1), .POOL(2), .ADDR_W(16)) u1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_en(wr_en1), .wr_ready(wr_ready1), .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    maxpool_ctrl #(.BITWIDTH(16), .IN_H(4), .IN_W(4), .CHANNELS(2), .POOL(2), .ADDR_W(16)) u2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .wr_en(wr_en2), .wr_ready(wr_ready2), .wr_addr(wr_addr2), .wr_data(wr_data2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] e(input int a, input int d);
        return {a[15:0], d[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_s1();
        for (int i = 0; i < 4; i++) q1.push_back(e(i, s1_data[i]));
    endtask

    task automatic start_run1(output int n);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 1;
    endtask

    task automatic wait_done1(inout int n);
        while (!done1 && n < 400) begin
            tick();
            n++;
        end
        if (!done1) check("done1_timeout", 32'(n), 0);
    endtask

    // Input buffer models: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en1) rd_data1 <= mem1[rd_addr1[3:0]];
        if (rd_en2) rd_data2 <= mem2[rd_addr2[4:0]];
    end

    always @(negedge clk) begin
        if (!rst && wr_en1 && wr_ready1) begin
            writes1++;
            check("wr1_pending", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) check("wr1", {wr_addr1, wr_data1}, q1.pop_front());
        end
        if (!rst && wr_en2 && wr_ready2) begin
            check("wr2_pending", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) check("wr2", {wr_addr2, wr_data2}, q2.pop_front());
        end
        if (done1) dones1++;
        if (rd_en1) rlog1.push_back(rd_addr1);
        if (rd_en2) rlog2.push_back(rd_addr2);
    end

    initial begin
        int n, b, d0, w0;
        rst = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        wr_ready1 = 1'b1;
        wr_ready2 = 1'b1;
        for (int i = 0; i < 16; i++) mem1[i] = 16'(i);
        for (int i = 0; i < 32; i++) mem2[i] = 16'(i % 16 + (i / 16) * 100);
        repeat (2) tick();
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_rd_en", 32'(rd_en1), 0);
        check("rst_wr_en", 32'(wr_en1), 0);
        check("rst_rd_addr", 32'(rd_addr1), 0);
        check("rst_wr_addr", 32'(wr_addr1), 0);
        check("rst_wr_data", 32'(wr_data1), 0);
        rst = 1'b0;
        tick();

        // Ramp 0..15: maxima 5, 7, 13, 15 and 25-cycle start-to-done
        push_s1();
        b = rlog1.size();
        d0 = dones1;
        start_run1(n);
        check("s1_busy", 32'(busy1), 1);
        wait_done1(n);
        check("s1_latency", 32'(n), 25);
        check("s1_busy_fin", 32'(busy1), 0);
        tick();
        check("s1_done_width", 32'(done1), 0);
        check("s1_dones", 32'(dones1 - d0), 1);
        for (int i = 0; i < 4; i++) check("s1_rd_addr", 32'(rlog1[b + i]), 32'(first_win[i]));
        check("s1_q_empty", 32'(q1.size()), 0);

        // Signed windows including the all-minimum floor case
        mem1[0] = -16'sd5;  mem1[1] = -16'sd2;  mem1[4] = -16'sd9;  mem1[5] = -16'sd3;
        mem1[2] = 16'h8000; mem1[3] = 16'h8000; mem1[6] = 16'h8000; mem1[7] = 16'h8000;
        mem1[8] = 16'd100;  mem1[9] = -16'sd1;  mem1[12] = 16'd7;   mem1[13] = 16'd3;
        mem1[10] = 16'h8000; mem1[11] = 16'h8000; mem1[14] = 16'h8000; mem1[15] = 16'h8001;
        q1.push_back(e(0, 16'hFFFE));
        q1.push_back(e(1, -32767));
        q1.push_back(e(2, 100));
        q1.push_back(e(3, -32767));
        start_run1(n);
        wait_done1(n);
        tick();
        check("s2_q_empty", 32'(q1.size()), 0);
        for (int i = 0; i < 16; i++) mem1[i] = 16'(i);

        // Backpressure: three stalled cycles in the first WRITE
        wr_ready1 = 1'b0;
        push_s1();
        start_run1(n);
        while (!wr_en1 && n < 50) begin
            tick();
            n++;
        end
        check("s4_write_cycle", 32'(n), 6);
        for (int i = 0; i < 3; i++) begin
            check("s4_hold_en", 32'(wr_en1), 1);
            check("s4_hold_addr", 32'(wr_addr1), 0);
            check("s4_hold_data", 32'(wr_data1), 5);
            check("s4_no_read", 32'(rd_en1), 0);
            tick();
            n++;
        end
        wr_ready1 = 1'b1;
        wait_done1(n);
        check("s4_latency", 32'(n), 28);
        tick();
        check("s4_q_empty", 32'(q1.size()), 0);

        // start while busy and in FIN is ignored; start in the next IDLE is taken
        push_s1();
        w0 = writes1;
        d0 = dones1;
        start_run1(n);
        while (n < 10) begin
            tick();
            n++;
        end
        start1 = 1'b1;
        tick();
        n++;
        start1 = 1'b0;
        wait_done1(n);
        check("s5_latency", 32'(n), 25);
        check("s5_writes", 32'(writes1 - w0), 4);
        push_s1();
        start1 = 1'b1;
        tick();
        check("s5_fin_start_ignored", 32'(busy1), 0);
        check("s5_dones_first", 32'(dones1 - d0), 1);
        tick();
        start1 = 1'b0;
        check("s5_idle_start", 32'(busy1), 1);
        n = 1;
        wait_done1(n);
        check("s5_rerun_latency", 32'(n), 25);
        tick();
        check("s5_dones", 32'(dones1 - d0), 2);
        check("s5_q_empty", 32'(q1.size()), 0);

        // Reset in the second READ cycle of output 2 aborts without a write or done
        q1.push_back(e(0, 5));
        start_run1(n);
        while (n < 8) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        check("s6_busy", 32'(busy1), 0);
        check("s6_done", 32'(done1), 0);
        check("s6_rd_en", 32'(rd_en1), 0);
        check("s6_wr_en", 32'(wr_en1), 0);
        check("s6_rd_addr", 32'(rd_addr1), 0);
        check("s6_wr_addr", 32'(wr_addr1), 0);
        check("s6_wr_data", 32'(wr_data1), 0);
        rst = 1'b0;
        w0 = writes1;
        d0 = dones1;
        repeat (5) tick();
        check("s6_no_write", 32'(writes1 - w0), 0);
        check("s6_no_done", 32'(dones1 - d0), 0);
        check("s6_q_empty", 32'(q1.size()), 0);
        push_s1();
        b = rlog1.size();
        start_run1(n);
        wait_done1(n);
        check("s6_rerun_latency", 32'(n), 25);
        tick();
        for (int i = 0; i < 4; i++) check("s6_rd_addr", 32'(rlog1[b + i]), 32'(first_win[i]));
        check("s6_rerun_q_empty", 32'(q1.size()), 0);

        // Two channels: channel 1 = channel 0 + 100
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 4; i++) q2.push_back(e(c * 4 + i, s1_data[i] + 100 * c));
        b = rlog2.size();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 1;
        while (!done2 && n < 400) begin
            tick();
            n++;
        end
        check("s3_latency", 32'(n), 49);
        tick();
        check("s3_ch1_first_read", 32'(rlog2[b + 16]), 16);
        check("s3_q_empty", 32'(q2.size()), 0);
        check("s3_busy_idle", 32'(busy2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maxpool_ctrl.md
Name: maxpool_ctrl

Overview:
Sequencer for the combinational window-max unit `Max` in the LeNet pooling stage. It walks a CHANNELS x IN_H x IN_W feature map stored row-major in a single-port read buffer and gathers each POOL x POOL window (stride POOL) into a register. It drives the registered window into one `Max` instance (LENGTH = POOL*POOL) and writes each result to the output buffer with a ready/valid write handshake. It is started and monitored by the layer controller via start/busy/done.

Parameters:
- BITWIDTH, 16: signed element width.
- IN_H, 28: input map height; must be a multiple of POOL.
- IN_W, 28: input map width; must be a multiple of POOL.
- CHANNELS, 6: number of feature maps processed per start.
- POOL, 2: window edge and stride.
- ADDR_W, 16: read/write address width; must hold CHANNELS*IN_H*IN_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write handshake.
- rd_en  out  1  read strobe to the input buffer.
- rd_addr  out  ADDR_W  input element address.
- rd_data  in  BITWIDTH  signed data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  output valid.
- wr_ready  in  1  output buffer accepts when wr_en&&wr_ready.
- wr_addr  out  ADDR_W  output element address.
- wr_data  out  BITWIDTH  pooled result.

Behaviour:
- Derived constants: OUT_H=IN_H/POOL, OUT_W=IN_W/POOL, WIN=POOL*POOL.
- Reset: state IDLE; busy, done, rd_en and wr_en are 0; rd_addr, wr_addr and all counters (c, oy, ox, k) are 0; window register cleared to 0. rst mid-operation aborts at once. No write is issued and done does not pulse.
- FSM states: IDLE, READ, LAST, WRITE, FIN.
- IDLE: start=1 -> READ. c, oy, ox and k are zeroed.
- READ: rd_en=1, one read per cycle for k=0..WIN-1, with dy=k/POOL and dx=k%POOL.
  - rd_addr = c*IN_H*IN_W + (oy*POOL+dy)*IN_W + (ox*POOL+dx).
  - rd_data arriving the cycle after read k is stored in window slot k.
  - After k=WIN-1 -> LAST.
- LAST: rd_en=0. Captures slot WIN-1, then -> WRITE.
- WRITE: wr_en=1.
  - wr_addr = c*OUT_H*OUT_W + oy*OUT_W + ox.
  - wr_data = Max(window), combinational from the registered window.
  - wr_en, wr_addr and wr_data are held stable while wr_ready=0.
  - On handshake: advance ox, wrapping to oy, then to c. Go to READ with k=0, or to FIN if this was the final output.
- FIN: done=1 for one cycle, busy=0 -> IDLE.
- start while not in IDLE is ignored.
- start in the FIN cycle is ignored; start is accepted in the following IDLE cycle.
- Timing with wr_ready held 1:
  - Each output costs WIN+2 cycles.
  - Total from the start cycle to the done pulse is CHANNELS*OUT_H*OUT_W*(WIN+2)+1 cycles.
- Arithmetic: signed compare is inherited from `Max`, which has an initial floor of -32767. A window that is entirely -32768 yields -32767. This is a documented, accepted behaviour.
- Address arithmetic is unsigned, ADDR_W wide, with no wrap in legal configurations.

Decomposition:
- Package maxpool_pkg holds:
  - state encoding (IDLE, READ, LAST, WRITE, FIN);
  - functions for OUT_H, OUT_W and WIN;
  - address-width check function.
- Sub-module: existing `Max` instantiated with BITWIDTH and LENGTH=WIN. The window register is packed slot k at bits [k*BITWIDTH +: BITWIDTH].
- Counters and address generation stay inline.

Test Plan:
1. IN_H=IN_W=4, CHANNELS=1, input = 0..15 row-major, wr_ready=1, start -> writes (addr,data) (0,5), (1,7), (2,13), (3,15).
   - done pulses once, 25 cycles after start.
   - rd_addr sequence for the first window is 0, 1, 4, 5.
2. Signed data: window {-5, -2, -9, -3} -> wr_data=-2 (16'hFFFE).
   - Window {-32768 x4} -> wr_data=-32767.
3. CHANNELS=2, 4x4, channel 1 = channel 0 + 100 -> wr_addr 4..7 carry 105, 107, 113, 115.
   - The first read of channel 1 is rd_addr=16.
4. Backpressure: wr_ready=0 for 3 cycles in the first WRITE -> wr_en, wr_addr=0 and wr_data=5 held stable.
   - No new rd_en until the handshake; done delayed by exactly 3 cycles.
5. start pulsed again while busy, and in the FIN cycle -> ignored; exactly 4 writes, one done.
   - start in the following IDLE cycle begins a new run.
6. rst asserted in the second READ cycle of output 2 -> next cycle all outputs 0 and state IDLE, no write, no done.
   - A subsequent start reproduces scenario 1 exactly.
